// File: rtl/mem_spi_pkg.sv
// Shared constants, state encoding and load-data helpers for the SPI memory data port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_spi_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    // Number of data bytes moved on the wire; unlisted encodings act as words.
    function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_nbytes = 3'd1;
            F3_H, F3_HU: f3_nbytes = 3'd2;
            default:     f3_nbytes = 3'd4;
        endcase
    endfunction

    // rx holds the received bytes in wire order, first byte in the most significant
    // occupied position. Memory is little-endian, so the first byte is bits [7:0].
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rx);
        logic [15:0] h;
        h = {rx[7:0], rx[15:8]};
        case (f3)
            F3_B:    load_extend = {{24{rx[7]}}, rx[7:0]};
            F3_BU:   load_extend = {24'h0, rx[7:0]};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: CLK_DIV divider, SCLK, bit counter, tx/rx shift registers.
// Latency: each bit lasts 2*CLK_DIV cycles (SCLK low half first); counters idle at 0 while i_run is low.
// Backpressure: none; the controlling FSM decides when to run, load and sample.
// Ports: i_clk/i_rst clock and sync reset; i_run enables the divider; i_load/i_load_dat load a
//        whole outgoing frame; i_rx_shift/i_miso shift one received bit; o_sclk/o_mosi drive the
//        wire; o_bit_start/o_bit_sample strobes; o_bit_cnt index of the current bit; o_rx_dat rx bits.
module spi_bit_engine #(
    parameter int CLK_DIV = 2,
    parameter int TXW     = 64,
    parameter int CNTW    = 7
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_run,
    input  logic            i_load,
    input  logic [TXW-1:0]  i_load_dat,
    input  logic            i_rx_shift,
    input  logic            i_miso,
    output logic            o_sclk,
    output logic            o_mosi,
    output logic            o_bit_start,
    output logic            o_bit_sample,
    output logic [CNTW-1:0] o_bit_cnt,
    output logic [31:0]     o_rx_dat
);

    localparam int             DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [DIVW-1:0] r_div;
    logic            r_sclk;
    logic [CNTW-1:0] r_bit_cnt;
    logic [TXW-1:0]  r_tx;
    logic [31:0]     r_rx;
    logic            w_half_end;

    assign w_half_end   = i_run && (r_div == DIV_LAST);
    // The edge closing the low half raises SCLK: that is where MISO is captured.
    assign o_bit_sample = w_half_end && !r_sclk;
    // The edge closing the high half drops SCLK and begins the next bit, so the
    // tx register advances on that same edge and MOSI only moves while SCLK is low.
    assign o_bit_start  = w_half_end && r_sclk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else begin
            if (!i_run) begin
                r_div     <= '0;
                r_sclk    <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_half_end) begin
                r_div  <= '0;
                r_sclk <= !r_sclk;
                if (r_sclk) begin
                    r_bit_cnt <= r_bit_cnt + CNT_ONE;
                end
            end else begin
                r_div <= r_div + DIV_ONE;
            end

            if (i_load) begin
                r_tx <= i_load_dat;
                r_rx <= '0;
            end else begin
                if (o_bit_start) begin
                    r_tx <= {r_tx[TXW-2:0], 1'b0};
                end
                if (i_rx_shift) begin
                    r_rx <= {r_rx[30:0], i_miso};
                end
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_tx[TXW-1];
    assign o_bit_cnt = r_bit_cnt;
    assign o_rx_dat  = r_rx;

endmodule

// File: rtl/mem_spi_data_port.sv
// Memory-stage data port: each load/store becomes one SPI READ/WRITE frame to a serial SRAM.
// Latency: request seen in IDLE at cycle 0, DONE at cycle 1 + (8+ADDR_BITS+8N)*2*CLK_DIV.
// Backpressure: StallM holds the pipeline from the request cycle until DONE (one low cycle per access).
// Ports: CLK/RST clock and sync active-high reset; MemReadM/MemWriteM/Funct3M/ALUResultM/WriteDataM
//        access request; ReadDataM registered extended load data; StallM pipeline hold;
//        SPI_SCLK/SPI_CS_N/SPI_MOSI/SPI_MISO serial SRAM interface.
module mem_spi_data_port
    import mem_spi_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BITS = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        SPI_SCLK,
    output logic        SPI_CS_N,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    localparam int             TXW       = 8 + ADDR_BITS + 32;
    localparam int             CNTW      = $clog2(TXW + 1);
    localparam logic [CNTW-1:0] CMD_LAST  = CNTW'(7);
    localparam logic [CNTW-1:0] ADDR_LAST = CNTW'(8 + ADDR_BITS - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [CNTW-1:0] r_last_bit;
    logic            r_cs_n;
    logic            r_stall;
    logic [31:0]     r_rdata;

    logic            w_req;
    logic            w_start;
    logic            w_enter_done;
    logic            w_run;
    logic            w_rx_shift;
    logic            w_sclk;
    logic            w_mosi;
    logic            w_bit_start;
    logic            w_bit_sample;
    logic [CNTW-1:0] w_bit_cnt;
    logic [CNTW-1:0] w_last_bit;
    logic [31:0]     w_rx_dat;
    logic [31:0]     w_tx_data;
    logic [TXW-1:0]  w_frame;
    logic            w_unused_addr;

    // Address bits above ADDR_BITS are not sent to the device.
    assign w_unused_addr = &{1'b0, ALUResultM};

    assign w_req = MemReadM | MemWriteM;
    assign w_run = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);

    // Whole frame is captured at request time so the pipeline inputs may change afterwards.
    // Store bytes go out lowest byte first; loads clock out zeros during the data phase.
    assign w_tx_data  = MemReadM ? 32'h0
                                 : {WriteDataM[7:0], WriteDataM[15:8], WriteDataM[23:16], WriteDataM[31:24]};
    assign w_frame    = {MemReadM ? SPI_CMD_READ : SPI_CMD_WRITE, ALUResultM[ADDR_BITS-1:0], w_tx_data};
    assign w_last_bit = ADDR_LAST + CNTW'({f3_nbytes(Funct3M), 3'b000});

    assign w_rx_shift = w_bit_sample && r_is_load && (r_state == DATA);

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next  = CMD;
                    w_start = 1'b1;
                end
            end
            CMD:  if (w_bit_start && (w_bit_cnt == CMD_LAST))  w_next = ADDR;
            ADDR: if (w_bit_start && (w_bit_cnt == ADDR_LAST)) w_next = DATA;
            DATA: begin
                if (w_bit_start && (w_bit_cnt == r_last_bit)) begin
                    w_next       = DONE;
                    w_enter_done = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_is_load  <= 1'b0;
            r_funct3   <= 3'b000;
            r_last_bit <= '0;
            r_cs_n     <= 1'b1;
            r_stall    <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_is_load  <= MemReadM;
                r_funct3   <= Funct3M;
                r_last_bit <= w_last_bit;
                r_cs_n     <= 1'b0;
                r_stall    <= 1'b1;
            end
            if (w_enter_done) begin
                r_cs_n  <= 1'b1;
                r_stall <= 1'b0;
                if (r_is_load) begin
                    r_rdata <= load_extend(r_funct3, w_rx_dat);
                end
            end
        end
    end

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV),
        .TXW     (TXW),
        .CNTW    (CNTW)
    ) u_engine (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_run        (w_run),
        .i_load       (w_start),
        .i_load_dat   (w_frame),
        .i_rx_shift   (w_rx_shift),
        .i_miso       (SPI_MISO),
        .o_sclk       (w_sclk),
        .o_mosi       (w_mosi),
        .o_bit_start  (w_bit_start),
        .o_bit_sample (w_bit_sample),
        .o_bit_cnt    (w_bit_cnt),
        .o_rx_dat     (w_rx_dat)
    );

    // The stall must be raised in the request cycle itself, before the FSM leaves IDLE.
    assign StallM    = r_stall | ((r_state == IDLE) && w_req && !RST);
    assign ReadDataM = r_rdata;
    assign SPI_SCLK  = w_sclk;
    assign SPI_CS_N  = r_cs_n;
    assign SPI_MOSI  = !r_cs_n && w_mosi;

endmodule
